// File: rtl/cmp_minmax_seq_if.sv
// Sample stream between operand source and the min/max sequencer.
interface cmp_minmax_seq_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cmp_minmax_seq.sv
// Burst min/max sequencer driving an external combinational comparator.
// Optional CMP_TIE_COUNT_EN adds tie_cnt (samples equal to the running max).
module cmp_minmax_seq #(
    parameter int DW = 4,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    cmp_minmax_seq_if.slave src,
    output logic          cmp_en,
    output logic [DW-1:0] cmp_a,
    output logic [DW-1:0] cmp_b,
    input  logic [1:0]    cmp_out,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] max_out,
    output logic [DW-1:0] min_out,
    output logic          cmp_err
`ifdef CMP_TIE_COUNT_EN
    ,
    output logic [LW-1:0] tie_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_WAIT, S_CMP_MAX, S_CMP_MIN, S_DONE
    } state_t;

    state_t        state, nxt;
    logic [LW-1:0] len_r, cnt, cnt_inc;
    logic [DW-1:0] max_r, min_r, sample_r;
    logic          xfer;

    assign xfer    = src.in_valid & src.in_ready;
    assign cnt_inc = cnt + 1'b1;
    assign max_out = max_r;
    assign min_out = min_r;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start && len != '0) nxt = S_FIRST;
            S_FIRST:   if (xfer) nxt = (len_r == LW'(1)) ? S_DONE : S_WAIT;
            S_WAIT:    if (xfer) nxt = S_CMP_MAX;
            S_CMP_MAX: nxt = S_CMP_MIN;
            S_CMP_MIN: nxt = (cnt_inc == len_r) ? S_DONE : S_WAIT;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            src.in_ready <= 1'b0;
            cmp_en       <= 1'b0;
            cmp_a        <= '0;
            cmp_b        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmp_err      <= 1'b0;
            len_r        <= '0;
            cnt          <= '0;
            max_r        <= '0;
            min_r        <= '0;
            sample_r     <= '0;
`ifdef CMP_TIE_COUNT_EN
            tie_cnt      <= '0;
`endif
        end else begin
            state        <= nxt;
            src.in_ready <= (nxt == S_FIRST) || (nxt == S_WAIT);
            busy         <= (nxt != S_IDLE);
            done         <= (state == S_DONE);
            cmp_en       <= (nxt == S_CMP_MAX) || (nxt == S_CMP_MIN);
            cmp_a        <= '0;
            cmp_b        <= '0;
            if (nxt == S_CMP_MAX) begin
                cmp_a <= src.in_data;
                cmp_b <= max_r;
            end else if (nxt == S_CMP_MIN) begin
                cmp_a <= sample_r;
                cmp_b <= min_r;
            end

            case (state)
                S_IDLE: if (start && len != '0) begin
                    len_r   <= len;
                    cnt     <= '0;
                    cmp_err <= 1'b0;
`ifdef CMP_TIE_COUNT_EN
                    tie_cnt <= '0;
`endif
                end
                S_FIRST: if (xfer) begin
                    max_r <= src.in_data;
                    min_r <= src.in_data;
                    cnt   <= LW'(1);
                end
                S_WAIT: if (xfer) sample_r <= src.in_data;
                // Unknown codes fall through to default and flag an error.
                S_CMP_MAX: case (cmp_out)
                    2'b10:   max_r <= sample_r;
                    2'b01:   ;
                    2'b00: begin
`ifdef CMP_TIE_COUNT_EN
                        tie_cnt <= tie_cnt + 1'b1;
`endif
                    end
                    default: cmp_err <= 1'b1;
                endcase
                S_CMP_MIN: begin
                    cnt <= cnt_inc;
                    case (cmp_out)
                        2'b01:   min_r <= sample_r;
                        2'b10, 2'b00: ;
                        default: cmp_err <= 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed bench for cmp_minmax_seq with a behavioural comparator.
module tb_cmp_minmax_seq;
    localparam int DW = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          cmp_en;
    logic [DW-1:0] cmp_a, cmp_b;
    logic [1:0]    cmp_out;
    logic          busy, done, cmp_err;
    logic [DW-1:0] max_out, min_out;
    logic          force_bad;
`ifdef CMP_TIE_COUNT_EN
    logic [LW-1:0] tie_cnt;
`endif

    cmp_minmax_seq_if #(.DW(DW)) bus ();

    cmp_minmax_seq #(.DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .src(bus),
        .cmp_en(cmp_en), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_out(cmp_out),
        .busy(busy), .done(done), .max_out(max_out), .min_out(min_out),
        .cmp_err(cmp_err)
`ifdef CMP_TIE_COUNT_EN
        , .tie_cnt(tie_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        if (force_bad)          cmp_out = 2'b11;
        else if (cmp_a > cmp_b) cmp_out = 2'b10;
        else if (cmp_a < cmp_b) cmp_out = 2'b01;
        else                    cmp_out = 2'b00;
    end

    int nvec = 0;
    int nmis = 0;
    logic [DW-1:0] smp [16];
    int done_cyc, done_cnt;
    bit saw_en, stall_drop;

    // Drives one burst: gap = idle cycles (with in_ready high) before each sample after
    // the first; force_at = compare index whose CMP_MAX gets code 11; rst_at = cycle to hit rst.
    task automatic run_burst(input int n, input int gap, input int force_at,
                             input bit poke, input int rst_at);
        int idx, stall, cmpk;
        bit xf, en_now, stalled;
        idx = 0; stall = 0; cmpk = 0;
        done_cyc = -1; done_cnt = 0; saw_en = 0; stall_drop = 0;
        @(negedge clk);
        start = 1'b1; len = LW'(n);
        @(posedge clk);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = poke && (c <= 4);
            stalled = 1'b0;
            if (idx < n && bus.in_ready && stall > 0) begin
                bus.in_valid = 1'b0; stall--; stalled = 1'b1;
            end else if (idx < n) begin
                bus.in_valid = 1'b1; bus.in_data = smp[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            en_now    = cmp_en;
            force_bad = en_now && (force_at >= 0) && (cmpk == 2 * force_at);
            xf        = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (xf) begin idx++; stall = gap; end
            if (en_now) begin cmpk++; saw_en = 1'b1; end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                bus.in_valid = 1'b0; force_bad = 1'b0; start = 1'b0;
                return;
            end
            #1;
            if (stalled && !bus.in_ready) stall_drop = 1'b1;
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        bus.in_valid = 1'b0; force_bad = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; force_bad = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({busy, done, bus.in_ready, cmp_en, cmp_err} !== 5'b0) begin
            nmis++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bus.in_ready, cmp_en, cmp_err});
        end
        nvec++;
        if ({cmp_a, cmp_b, max_out, min_out} !== 16'h0) begin
            nmis++; $display("FAIL reset_data: got %h want 0000", {cmp_a, cmp_b, max_out, min_out});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        smp[0] = 4'd5; smp[1] = 4'd9; smp[2] = 4'd2; smp[3] = 4'd9;
        run_burst(4, 0, -1, 1'b0, 0);
        nvec++; if (done_cyc !== 11) begin nmis++; $display("FAIL basic_done_cycle: got %0d want 11", done_cyc); end
        nvec++; if (done_cnt !== 1) begin nmis++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        nvec++; if (max_out !== 4'd9) begin nmis++; $display("FAIL basic_max: got %0d want 9", max_out); end
        nvec++; if (min_out !== 4'd2) begin nmis++; $display("FAIL basic_min: got %0d want 2", min_out); end
        nvec++; if (cmp_err !== 1'b0) begin nmis++; $display("FAIL basic_err: got %b want 0", cmp_err); end
        nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL basic_busy_after: got %b want 0", busy); end
`ifdef CMP_TIE_COUNT_EN
        nvec++; if (tie_cnt !== 4'd1) begin nmis++; $display("FAIL basic_ties: got %0d want 1", tie_cnt); end
`endif
    endtask

    task automatic test_single();
        smp[0] = 4'd7;
        run_burst(1, 0, -1, 1'b0, 0);
        nvec++; if (done_cyc !== 2) begin nmis++; $display("FAIL single_done_cycle: got %0d want 2", done_cyc); end
        nvec++; if (max_out !== 4'd7) begin nmis++; $display("FAIL single_max: got %0d want 7", max_out); end
        nvec++; if (min_out !== 4'd7) begin nmis++; $display("FAIL single_min: got %0d want 7", min_out); end
        nvec++; if (saw_en !== 1'b0) begin nmis++; $display("FAIL single_cmp_en: got %b want 0", saw_en); end
    endtask

    task automatic test_stall();
        smp[0] = 4'd15; smp[1] = 4'd0; smp[2] = 4'd15;
        run_burst(3, 2, -1, 1'b0, 0);
        nvec++; if (done_cyc !== 12) begin nmis++; $display("FAIL stall_done_cycle: got %0d want 12", done_cyc); end
        nvec++; if (stall_drop !== 1'b0) begin nmis++; $display("FAIL stall_ready: got drop=%b want 0", stall_drop); end
        nvec++; if (max_out !== 4'd15) begin nmis++; $display("FAIL stall_max: got %0d want 15", max_out); end
        nvec++; if (min_out !== 4'd0) begin nmis++; $display("FAIL stall_min: got %0d want 0", min_out); end
    endtask

    task automatic test_ignored();
        @(negedge clk); start = 1'b1; len = '0;
        @(posedge clk); #1;
        nvec++; if ({busy, bus.in_ready} !== 2'b00) begin nmis++; $display("FAIL len0_start: got %b want 00", {busy, bus.in_ready}); end
        @(negedge clk); start = 1'b0;
        smp[0] = 4'd3; smp[1] = 4'd1;
        run_burst(2, 0, -1, 1'b1, 0);
        nvec++; if (done_cyc !== 5) begin nmis++; $display("FAIL busy_start_done_cycle: got %0d want 5", done_cyc); end
        nvec++; if (done_cnt !== 1) begin nmis++; $display("FAIL busy_start_pulses: got %0d want 1", done_cnt); end
        nvec++; if ({max_out, min_out} !== 8'h31) begin nmis++; $display("FAIL busy_start_result: got %h want 31", {max_out, min_out}); end
        nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL busy_start_idle: got %b want 0", busy); end
    endtask

    task automatic test_cmp_err();
        smp[0] = 4'd4; smp[1] = 4'd6; smp[2] = 4'd1;
        run_burst(3, 0, 0, 1'b0, 0);
        nvec++; if (done_cyc !== 8) begin nmis++; $display("FAIL err_done_cycle: got %0d want 8", done_cyc); end
        nvec++; if (cmp_err !== 1'b1) begin nmis++; $display("FAIL err_sticky: got %b want 1", cmp_err); end
        nvec++; if (max_out !== 4'd4) begin nmis++; $display("FAIL err_max: got %0d want 4", max_out); end
        nvec++; if (min_out !== 4'd1) begin nmis++; $display("FAIL err_min: got %0d want 1", min_out); end
        smp[0] = 4'd2; smp[1] = 4'd2;
        run_burst(2, 0, -1, 1'b0, 0);
        nvec++; if (cmp_err !== 1'b0) begin nmis++; $display("FAIL err_clear: got %b want 0", cmp_err); end
        nvec++; if ({max_out, min_out} !== 8'h22) begin nmis++; $display("FAIL tie_result: got %h want 22", {max_out, min_out}); end
`ifdef CMP_TIE_COUNT_EN
        nvec++; if (tie_cnt !== 4'd1) begin nmis++; $display("FAIL tie_count: got %0d want 1", tie_cnt); end
`endif
    endtask

    task automatic test_rst_mid();
        bit extra;
        smp[0] = 4'd6; smp[1] = 4'd9; smp[2] = 4'd1; smp[3] = 4'd3; smp[4] = 4'd8;
        run_burst(5, 0, -1, 1'b0, 3);
        nvec++;
        if ({busy, done, bus.in_ready, cmp_en, cmp_err} !== 5'b0) begin
            nmis++; $display("FAIL midrst_ctrl: got %b want 00000", {busy, done, bus.in_ready, cmp_en, cmp_err});
        end
        nvec++;
        if ({cmp_a, cmp_b, max_out, min_out} !== 16'h0) begin
            nmis++; $display("FAIL midrst_data: got %h want 0000", {cmp_a, cmp_b, max_out, min_out});
        end
        @(negedge clk); rst = 1'b0;
        extra = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) extra = 1'b1;
        end
        nvec++; if (extra !== 1'b0) begin nmis++; $display("FAIL midrst_no_done: got activity=%b want 0", extra); end
        smp[0] = 4'd3; smp[1] = 4'd8;
        run_burst(2, 0, -1, 1'b0, 0);
        nvec++; if (done_cyc !== 5) begin nmis++; $display("FAIL post_rst_done_cycle: got %0d want 5", done_cyc); end
        nvec++; if (max_out !== 4'd8) begin nmis++; $display("FAIL post_rst_max: got %0d want 8", max_out); end
        nvec++; if (min_out !== 4'd3) begin nmis++; $display("FAIL post_rst_min: got %0d want 3", min_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_ignored();
        test_cmp_err();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
